// File: rtl/eeprom_93c46_responder.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_93c46_responder
// Description : Microwire slave modelling an AT93C46 in x16 organisation
//               (64 x 16 words). Decodes READ/WRITE/ERASE/EWEN/EWDS/ERAL/WRAL
//               and emulates the self-timed program cycle with ready/busy on DO.
// Revision    : 1.0 - initial release
// ============================================================================
module eeprom_93c46_responder #(
    parameter int          BUSY_CYCLES = 200,
    parameter logic [15:0] INIT_WORD   = 16'hFFFF
) (
    input  logic CLK_200M,
    input  logic SYS_RSTn,
    input  logic EEPROM_CS_IN,
    input  logic EEPROM_SK_IN,
    input  logic EEPROM_DI_IN,
    output logic EEPROM_DO_OUT,
    output logic WEN_OUT,
    output logic BUSY_OUT
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] OPC  = 3'd1;
    localparam logic [2:0] ADR  = 3'd2;
    localparam logic [2:0] RDAT = 3'd3;
    localparam logic [2:0] WDAT = 3'd4;
    localparam logic [2:0] BUSY = 3'd5;

    localparam logic [15:0] BUSY_LAST = 16'(BUSY_CYCLES - 1);

    logic [1:0]  cs_sync, sk_sync, di_sync;
    logic        cs_prev, sk_prev;
    logic [2:0]  state;
    logic [1:0]  opcode;
    logic [5:0]  addr;
    logic [4:0]  bit_cnt;
    logic [15:0] shift;
    logic        prog, prog_all, wen, do_reg;
    logic [15:0] busy_cnt;
    logic [5:0]  wr_addr;
    logic        wr_active;

    // The array has no reset. Words are stored XORed with INIT_WORD so that an
    // array that powers up all-zero reads back as INIT_WORD everywhere.
    logic [15:0] mem [0:63];

    logic        cs, sk_rise, cs_fall, di, mem_we;
    logic [5:0]  addr_full;
    logic [15:0] rd_word, next_word;

    assign cs        = cs_sync[1];
    assign di        = di_sync[1];
    assign sk_rise   = sk_sync[1] & ~sk_prev;
    assign cs_fall   = cs_prev & ~cs;
    assign addr_full = {addr[4:0], di};
    assign rd_word   = mem[addr_full] ^ INIT_WORD;
    assign next_word = mem[addr + 6'd1] ^ INIT_WORD;
    assign mem_we    = (state == BUSY) && wr_active;

    assign EEPROM_DO_OUT = do_reg;
    assign WEN_OUT       = wen;
    assign BUSY_OUT      = (state == BUSY);

    // Array write port: one word per clock while the program cycle runs.
    always_ff @(posedge CLK_200M) begin
        if (mem_we)
            mem[wr_addr] <= shift ^ INIT_WORD;
    end

    // Synchronisers, edge detection and the Microwire command FSM.
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            cs_sync   <= 2'b00;
            sk_sync   <= 2'b00;
            di_sync   <= 2'b00;
            cs_prev   <= 1'b0;
            sk_prev   <= 1'b0;
            state     <= IDLE;
            opcode    <= 2'b00;
            addr      <= 6'd0;
            bit_cnt   <= 5'd0;
            shift     <= 16'd0;
            prog      <= 1'b0;
            prog_all  <= 1'b0;
            wen       <= 1'b0;
            do_reg    <= 1'b1;
            busy_cnt  <= 16'd0;
            wr_addr   <= 6'd0;
            wr_active <= 1'b0;
        end else begin
            cs_sync <= {cs_sync[0], EEPROM_CS_IN};
            sk_sync <= {sk_sync[0], EEPROM_SK_IN};
            di_sync <= {di_sync[0], EEPROM_DI_IN};
            cs_prev <= cs;
            sk_prev <= sk_sync[1];

            if (state == BUSY) begin
                // Serial inputs ignored; DO reports busy whenever CS is high.
                do_reg <= ~cs;
                if (wr_active) begin
                    if (!prog_all || wr_addr == 6'd63)
                        wr_active <= 1'b0;
                    wr_addr <= wr_addr + 6'd1;
                end
                if (busy_cnt == 16'd0)
                    state <= IDLE;
                else
                    busy_cnt <= busy_cnt - 16'd1;
            end else if (!cs) begin
                // CS low ends the command; checked before SK so a coincident
                // SK rise is dropped.
                do_reg  <= 1'b1;
                bit_cnt <= 5'd0;
                prog    <= 1'b0;
                if (cs_fall && state == WDAT && prog && bit_cnt == 5'd16 && wen) begin
                    state     <= BUSY;
                    busy_cnt  <= BUSY_LAST;
                    wr_active <= 1'b1;
                    wr_addr   <= prog_all ? 6'd0 : addr;
                end else begin
                    state <= IDLE;
                end
            end else begin
                if (state != RDAT)
                    do_reg <= 1'b1;
                if (sk_rise) begin
                    case (state)
                        IDLE: begin
                            if (di) begin
                                state   <= OPC;
                                bit_cnt <= 5'd0;
                            end
                        end
                        OPC: begin
                            opcode  <= {opcode[0], di};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd1) begin
                                state   <= ADR;
                                bit_cnt <= 5'd0;
                            end
                        end
                        ADR: begin
                            addr    <= addr_full;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd5) begin
                                // Non-data commands park in WDAT with the data
                                // counter already full so extra bits are ignored.
                                bit_cnt  <= 5'd16;
                                prog     <= 1'b0;
                                prog_all <= 1'b0;
                                state    <= WDAT;
                                case (opcode)
                                    2'b10: begin
                                        state   <= RDAT;
                                        do_reg  <= 1'b0;
                                        shift   <= rd_word;
                                        bit_cnt <= 5'd0;
                                    end
                                    2'b01: begin
                                        prog    <= 1'b1;
                                        bit_cnt <= 5'd0;
                                    end
                                    2'b11: begin
                                        prog  <= 1'b1;
                                        shift <= 16'hFFFF;
                                    end
                                    default: begin
                                        case (addr_full[5:4])
                                            2'b11: wen <= 1'b1;
                                            2'b00: wen <= 1'b0;
                                            2'b10: begin
                                                prog     <= 1'b1;
                                                prog_all <= 1'b1;
                                                shift    <= 16'hFFFF;
                                            end
                                            default: begin
                                                prog     <= 1'b1;
                                                prog_all <= 1'b1;
                                                bit_cnt  <= 5'd0;
                                            end
                                        endcase
                                    end
                                endcase
                            end
                        end
                        RDAT: begin
                            do_reg <= shift[15];
                            if (bit_cnt == 5'd15) begin
                                bit_cnt <= 5'd0;
                                addr    <= addr + 6'd1;
                                shift   <= next_word;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                shift   <= {shift[14:0], 1'b0};
                            end
                        end
                        WDAT: begin
                            if (bit_cnt < 5'd16) begin
                                shift   <= {shift[14:0], di};
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eeprom_93c46_responder.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_eeprom_93c46_responder
// Description : Self-checking bench: table of commands with hand-derived
//               expectations, directed corner sequences, then random commands
//               checked against a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eeprom_93c46_responder;

    logic clk = 1'b0;
    logic rstn, cs, sk, di;
    wire  do_o, wen_o, busy_o;

    eeprom_93c46_responder #(.BUSY_CYCLES(200), .INIT_WORD(16'hFFFF)) dut (
        .CLK_200M(clk), .SYS_RSTn(rstn), .EEPROM_CS_IN(cs), .EEPROM_SK_IN(sk),
        .EEPROM_DI_IN(di), .EEPROM_DO_OUT(do_o), .WEN_OUT(wen_o), .BUSY_OUT(busy_o)
    );

    always #2.5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Busy-window monitor: length of the most recent BUSY_OUT pulse in cycles.
    int busy_run = 0, busy_len = 0, busy_events = 0;
    always @(negedge clk) begin
        if (busy_o) busy_run++;
        else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_events++;
            busy_run = 0;
        end
    end

    // Reference model: the word array and the write-enable latch.
    logic [15:0] m_mem [64];
    logic        m_wen;

    function automatic logic model_apply(input logic [1:0] op, input logic [5:0] a,
                                         input logic [15:0] d, input int nd);
        logic prog_ok = 1'b0;
        case (op)
            2'b01: if (m_wen && nd == 16) begin m_mem[a] = d; prog_ok = 1'b1; end
            2'b11: if (m_wen) begin m_mem[a] = 16'hFFFF; prog_ok = 1'b1; end
            2'b00: begin
                case (a[5:4])
                    2'b11: m_wen = 1'b1;
                    2'b00: m_wen = 1'b0;
                    2'b10: if (m_wen) begin
                        for (int k = 0; k < 64; k++) m_mem[k] = 16'hFFFF;
                        prog_ok = 1'b1;
                    end
                    default: if (m_wen && nd == 16) begin
                        for (int k = 0; k < 64; k++) m_mem[k] = d;
                        prog_ok = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
        return prog_ok;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SK period (40 clocks = 5 MHz); DO is sampled late in the high phase.
    task automatic sk_bit(input logic b, output logic d);
        di = b;
        tick(10);
        sk = 1'b1;
        tick(10);
        d  = do_o;
        sk = 1'b0;
        tick(20);
    endtask

    task automatic send_hdr(input logic [1:0] op, input logic [5:0] a, output logic d);
        logic [8:0] h;
        h = {1'b1, op, a};
        for (int i = 8; i >= 0; i--) sk_bit(h[i], d);
    endtask

    task automatic cs_on;
        cs = 1'b1;
        tick(4);
    endtask

    task automatic cs_off;
        cs = 1'b0; sk = 1'b0; di = 1'b0;
        tick(8);
    endtask

    task automatic get_word(output logic [15:0] w);
        logic d;
        w = 16'h0;
        for (int i = 0; i < 16; i++) begin
            sk_bit(1'b0, d);
            w = {w[14:0], d};
        end
    endtask

    task automatic do_read(input logic [5:0] a, output logic dummy, output logic [15:0] w);
        cs_on();
        send_hdr(2'b10, a, dummy);
        get_word(w);
        cs_off();
    endtask

    // Issue a non-read command; report whether a busy window followed and its length.
    task automatic do_cmd(input logic [1:0] op, input logic [5:0] a, input logic [15:0] data,
                          input int nd, output logic saw_busy, output int blen);
        logic d;
        int   ev0;
        bit   done;
        cs_on();
        send_hdr(op, a, d);
        for (int i = 0; i < nd; i++) sk_bit(data[15-i], d);
        ev0 = busy_events;
        cs = 1'b0; sk = 1'b0; di = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (busy_o || busy_events != ev0) saw_busy = 1'b1;
        end
        blen = 0;
        if (saw_busy) begin
            done = 1'b0;
            for (int i = 0; i < 1000 && !done; i++) begin
                tick(1);
                if (busy_events != ev0) done = 1'b1;
            end
            if (!done) check("busy_timeout", 32'd0, 32'd1);
            blen = busy_len;
        end
        tick(8);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  addr;
        logic [15:0] data;
        int          nd;
        logic        exp_wen;
        logic        exp_busy;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic        d, dummy, sb, eb;
        logic [15:0] w, w2;
        int          bl, ev0;
        bit          done;

        vt[0]  = '{2'b00, 6'h30, 16'h0000, 0,  1'b1, 1'b0, 16'h0000}; // EWEN
        vt[1]  = '{2'b01, 6'h05, 16'hA5C3, 16, 1'b1, 1'b1, 16'h0000}; // WRITE
        vt[2]  = '{2'b10, 6'h05, 16'h0000, 0,  1'b1, 1'b0, 16'hA5C3}; // READ
        vt[3]  = '{2'b00, 6'h00, 16'h0000, 0,  1'b0, 1'b0, 16'h0000}; // EWDS
        vt[4]  = '{2'b01, 6'h05, 16'h1234, 16, 1'b0, 1'b0, 16'h0000}; // WRITE blocked
        vt[5]  = '{2'b10, 6'h05, 16'h0000, 0,  1'b0, 1'b0, 16'hA5C3}; // READ
        vt[6]  = '{2'b00, 6'h3F, 16'h0000, 0,  1'b1, 1'b0, 16'h0000}; // EWEN
        vt[7]  = '{2'b11, 6'h05, 16'h0000, 0,  1'b1, 1'b1, 16'h0000}; // ERASE
        vt[8]  = '{2'b10, 6'h05, 16'h0000, 0,  1'b1, 1'b0, 16'hFFFF}; // READ
        vt[9]  = '{2'b01, 6'h3F, 16'h8001, 16, 1'b1, 1'b1, 16'h0000}; // WRITE
        vt[10] = '{2'b01, 6'h00, 16'h7E11, 16, 1'b1, 1'b1, 16'h0000}; // WRITE
        vt[11] = '{2'b01, 6'h05, 16'hA5C3, 16, 1'b1, 1'b1, 16'h0000}; // WRITE

        for (int k = 0; k < 64; k++) m_mem[k] = 16'hFFFF;
        m_wen = 1'b0;

        rstn = 1'b0; cs = 1'b0; sk = 1'b0; di = 1'b0;
        tick(5);
        check("reset_do", {31'd0, do_o}, 32'd1);
        check("reset_wen", {31'd0, wen_o}, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        rstn = 1'b1;
        tick(5);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].op == 2'b10) begin
                do_read(vt[i].addr, dummy, w);
                check($sformatf("vec%0d_dummy", i), {31'd0, dummy}, 32'd0);
                check($sformatf("vec%0d_rd", i), {16'd0, w}, {16'd0, vt[i].exp_rd});
            end else begin
                eb = model_apply(vt[i].op, vt[i].addr, vt[i].data, vt[i].nd);
                do_cmd(vt[i].op, vt[i].addr, vt[i].data, vt[i].nd, sb, bl);
                check($sformatf("vec%0d_busy", i), {31'd0, sb}, {31'd0, vt[i].exp_busy});
            end
            check($sformatf("vec%0d_wen", i), {31'd0, wen_o}, {31'd0, vt[i].exp_wen});
        end

        // Sequential read wrapping 0x3F -> 0x00 with no second dummy bit.
        cs_on();
        send_hdr(2'b10, 6'h3F, dummy);
        get_word(w);
        get_word(w2);
        cs_off();
        check("seq_dummy", {31'd0, dummy}, 32'd0);
        check("seq_w3f", {16'd0, w}, 32'h8001);
        check("seq_w00", {16'd0, w2}, 32'h7E11);

        // WRAL 0x5555: busy length, DO low while CS high during busy, then ready.
        eb = model_apply(2'b00, 6'h10, 16'h5555, 16);
        cs_on();
        send_hdr(2'b00, 6'h10, d);
        for (int i = 0; i < 16; i++) sk_bit(i[0] ? 1'b1 : 1'b0, d);
        ev0 = busy_events;
        cs = 1'b0; sk = 1'b0; di = 1'b0;
        tick(6);
        check("wral_busy", {31'd0, busy_o}, 32'd1);
        cs = 1'b1;
        tick(6);
        check("wral_do_busy", {31'd0, do_o}, 32'd0);
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            tick(1);
            if (busy_events != ev0) done = 1'b1;
        end
        check("wral_done", {31'd0, done}, 32'd1);
        check("wral_len", busy_len, 32'd200);
        tick(4);
        check("wral_ready", {31'd0, do_o}, 32'd1);
        cs_off();
        do_read(6'h00, dummy, w);
        check("wral_rd00", {16'd0, w}, 32'h5555);
        do_read(6'h20, dummy, w);
        check("wral_rd20", {16'd0, w}, 32'h5555);
        do_read(6'h3F, dummy, w);
        check("wral_rd3f", {16'd0, w}, 32'h5555);

        // WRITE with only 15 data bits: discarded.
        eb = model_apply(2'b01, 6'h0A, 16'hBEEF, 15);
        do_cmd(2'b01, 6'h0A, 16'hBEEF, 15, sb, bl);
        check("short_busy", {31'd0, sb}, 32'd0);
        do_read(6'h0A, dummy, w);
        check("short_rd", {16'd0, w}, 32'h5555);

        // Reset pulse in the middle of a READ.
        cs_on();
        send_hdr(2'b10, 6'h20, d);
        sk_bit(1'b0, d);
        sk_bit(1'b0, d);
        rstn = 1'b0;
        tick(3);
        check("rst_do", {31'd0, do_o}, 32'd1);
        check("rst_wen", {31'd0, wen_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        rstn = 1'b1;
        m_wen = 1'b0;
        tick(2);
        cs_off();
        do_read(6'h00, dummy, w);
        check("rst_next_dummy", {31'd0, dummy}, 32'd0);
        check("rst_next_rd", {16'd0, w}, 32'h5555);

        // Random commands against the reference model.
        for (int n = 0; n < 20; n++) begin
            logic [5:0]  a;
            logic [15:0] dt;
            int          kind, nd;
            logic [1:0]  op;
            a    = 6'($urandom_range(0, 63));
            dt   = 16'($urandom);
            kind = $urandom_range(0, 6);
            nd   = ($urandom_range(0, 4) == 0) ? 15 : 16;
            case (kind)
                0, 1: op = 2'b10;
                2:    op = 2'b01;
                3:    op = 2'b11;
                4:    begin op = 2'b00; a[5:4] = 2'b11; end
                5:    begin op = 2'b00; a[5:4] = 2'b00; end
                default: begin op = 2'b00; a[5:4] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01; end
            endcase
            if (op == 2'b10) begin
                do_read(a, dummy, w);
                check($sformatf("rnd%0d_rd", n), {16'd0, w}, {16'd0, m_mem[a]});
            end else begin
                if (op == 2'b11 || (op == 2'b00 && a[5:4] != 2'b01)) nd = 0;
                eb = model_apply(op, a, dt, nd);
                do_cmd(op, a, dt, nd, sb, bl);
                check($sformatf("rnd%0d_busy", n), {31'd0, sb}, {31'd0, eb});
                check($sformatf("rnd%0d_wen", n), {31'd0, wen_o}, {31'd0, m_wen});
            end
        end
        for (int n = 0; n < 6; n++) begin
            logic [5:0] a;
            a = 6'($urandom_range(0, 63));
            do_read(a, dummy, w);
            check($sformatf("final%0d_rd", n), {16'd0, w}, {16'd0, m_mem[a]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
